// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: program-memory handshake plus the issue port to the control unit.
// master is the fetch unit, slave is the memory/control-unit side.
interface instr_fetch_if #(
    parameter int unsigned ProgDepth = 32
);
    localparam int unsigned AddrW = $clog2(ProgDepth);

    logic             start;
    logic             mem_rd;
    logic [AddrW-1:0] mem_addr;
    logic [7:0]       mem_data;
    logic             mem_ready;
    logic             stall;
    logic             branch_en;
    logic [AddrW-1:0] branch_addr;
    logic             en;
    logic [2:0]       opcode;
    logic [4:0]       operand;
    logic [AddrW-1:0] pc;
    logic             halted;

    modport master (
        input  start, mem_data, mem_ready, stall, branch_en, branch_addr,
        output mem_rd, mem_addr, en, opcode, operand, pc, halted
    );

    modport slave (
        output start, mem_data, mem_ready, stall, branch_en, branch_addr,
        input  mem_rd, mem_addr, en, opcode, operand, pc, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads program memory at PC, latches the word into IR and issues
// it to the control unit with a one-cycle strobe; branches flush, a halt opcode parks the unit.
module instr_fetch #(
    parameter int unsigned ProgDepth = 32,
    parameter logic [2:0]  HaltOp    = 3'b111
) (
    input logic            clk,
    input logic            rst_n,
    instr_fetch_if.master  bus
);
    localparam int unsigned AddrW = $clog2(ProgDepth);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] pc_q, pc_d, pc_inc;
    logic [7:0]       ir_q, ir_d;
    logic             ir_is_halt;

    assign ir_is_halt = (ir_q[7:5] == HaltOp);
    // Explicit wrap so a non-power-of-two depth still stays inside the program.
    assign pc_inc     = (pc_q == AddrW'(ProgDepth - 1)) ? '0 : pc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle, StHalt: begin
                if (bus.start) state_d = StFetch;
            end
            StFetch: begin
                // Branch wins over a returning word: the fetched data is dropped.
                if (bus.branch_en) begin
                    pc_d = bus.branch_addr;
                end else if (bus.mem_ready) begin
                    ir_d    = bus.mem_data;
                    pc_d    = pc_inc;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.branch_en) begin
                    pc_d    = bus.branch_addr;
                    state_d = StFetch;
                end else if (!bus.stall) begin
                    state_d = ir_is_halt ? StHalt : StFetch;
                end
            end
        endcase
    end

    always_comb begin
        bus.mem_rd = (state_q == StFetch);
        bus.en     = (state_q == StIssue) && !bus.stall && !bus.branch_en && !ir_is_halt;
        bus.halted = (state_q == StHalt);
    end

    assign bus.mem_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.opcode   = ir_q[7:5];
    assign bus.operand  = ir_q[4:0];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the fetch/issue behaviour.
module tb_instr_fetch;
    localparam int unsigned Depth  = 32;
    localparam logic [2:0]  HaltOp = 3'b111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_if #(.ProgDepth(Depth)) bus ();

    instr_fetch #(.ProgDepth(Depth), .HaltOp(HaltOp)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [Depth];
    assign bus.mem_data = mem[bus.mem_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // Model: running or not, whether an instruction is held waiting to issue, halted flag.
    bit         m_run, m_pend, m_halt;
    int         m_pc;
    logic [7:0] m_ir;

    always @(negedge clk) begin
        bit exp_en;
        if (!rst_n) begin
            m_run = 0; m_pend = 0; m_halt = 0; m_pc = 0; m_ir = '0;
        end
        exp_en = m_run && m_pend && !bus.branch_en && !bus.stall && (m_ir[7:5] != HaltOp);
        chk("m_rd",    bus.mem_rd,   m_run && !m_pend);
        chk("m_addr",  bus.mem_addr, m_pc);
        chk("m_pc",    bus.pc,       m_pc);
        chk("m_en",    bus.en,       exp_en);
        chk("m_op",    bus.opcode,   m_ir[7:5]);
        chk("m_opnd",  bus.operand,  m_ir[4:0]);
        chk("m_halt",  bus.halted,   m_halt);
        if (rst_n) begin
            if (!m_run) begin
                if (bus.start) begin m_run = 1; m_halt = 0; m_pend = 0; end
            end else if (bus.branch_en) begin
                m_pc = bus.branch_addr; m_pend = 0;
            end else if (!m_pend) begin
                if (bus.mem_ready) begin
                    m_ir = mem[m_pc]; m_pc = (m_pc + 1) % Depth; m_pend = 1;
                end
            end else if (!bus.stall) begin
                m_pend = 0;
                if (m_ir[7:5] == HaltOp) begin m_run = 0; m_halt = 1; end
            end
        end
    end

    task automatic drive(input bit s, input bit r, input bit st, input bit b,
                         input logic [4:0] a);
        @(posedge clk); #2;
        bus.start = s; bus.mem_ready = r; bus.stall = st; bus.branch_en = b;
        bus.branch_addr = a;
    endtask

    task automatic look;
        @(negedge clk); #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},   bus.mem_rd, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_en"},   bus.en, 0);
        chk({tag, "_op"},   bus.opcode, 0);
        chk({tag, "_opnd"}, bus.operand, 0);
        chk({tag, "_pc"},   bus.pc, 0);
        chk({tag, "_halt"}, bus.halted, 0);
    endtask

    initial begin
        bus.start = 0; bus.mem_ready = 0; bus.stall = 0; bus.branch_en = 0;
        bus.branch_addr = '0;
        for (int i = 0; i < Depth; i++) mem[i] = 8'h40 | 8'(i);
        mem[0] = 8'h25; mem[1] = 8'h41; mem[2] = 8'hE0; mem[3] = 8'h6A; mem[4] = 8'h8C;
        mem[5'h1E] = 8'h33; mem[5'h1F] = 8'h54;

        look; chk_zero("rst");
        @(posedge clk); #2 rst_n = 1;
        look; chk_zero("idle");

        // Zero-wait first fetch and issue, then run into the halt word.
        drive(1, 1, 0, 0, 0); look; chk("c0_rd", bus.mem_rd, 0);
        drive(0, 1, 0, 0, 0); look; chk("c1_rd", bus.mem_rd, 1); chk("c1_addr", bus.mem_addr, 0);
        drive(0, 1, 0, 0, 0); look;
        chk("c2_en", bus.en, 1); chk("c2_op", bus.opcode, 1);
        chk("c2_opnd", bus.operand, 5); chk("c2_pc", bus.pc, 1);
        drive(0, 1, 0, 0, 0); look; chk("f1_addr", bus.mem_addr, 1);
        drive(0, 1, 0, 0, 0); look; chk("i1_en", bus.en, 1); chk("i1_op", bus.opcode, 2);
        drive(0, 1, 0, 0, 0); look; chk("f2_addr", bus.mem_addr, 2);
        drive(0, 1, 0, 0, 0); look; chk("ihalt_en", bus.en, 0);
        drive(0, 1, 0, 0, 0); look;
        chk("h_halt", bus.halted, 1); chk("h_rd", bus.mem_rd, 0); chk("h_pc", bus.pc, 3);

        // Resume from halt with three wait cycles on memory.
        drive(1, 0, 0, 0, 0); look; chk("hs_halt", bus.halted, 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, (k == 3), 0, 0, 0); look;
            chk("w_rd", bus.mem_rd, 1); chk("w_addr", bus.mem_addr, 3);
            chk("w_halt", bus.halted, 0); chk("w_en", bus.en, 0);
        end
        drive(0, 0, 0, 0, 0); look;
        chk("w_en1", bus.en, 1); chk("w_op", bus.opcode, 3); chk("w_opnd", bus.operand, 10);

        // Two stall cycles in issue.
        drive(0, 1, 0, 0, 0); look; chk("s_faddr", bus.mem_addr, 4);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 0, 0); look; chk("s_en", bus.en, 0); chk("s_pc", bus.pc, 5);
        end
        drive(0, 0, 0, 0, 0); look;
        chk("s_en1", bus.en, 1); chk("s_op", bus.opcode, 4); chk("s_opnd", bus.operand, 12);
        drive(0, 0, 0, 0, 0); look; chk("s_en2", bus.en, 0); chk("s_addr", bus.mem_addr, 5);

        // Branch in the same cycle as the memory reply, then PC wrap.
        drive(0, 1, 0, 1, 5'h1E); look; chk("b_en", bus.en, 0);
        drive(0, 1, 0, 0, 0); look;
        chk("b_addr", bus.mem_addr, 5'h1E); chk("b_rd", bus.mem_rd, 1); chk("b_en2", bus.en, 0);
        drive(0, 1, 0, 0, 0); look;
        chk("b_pc", bus.pc, 5'h1F); chk("b_op", bus.opcode, 1); chk("b_opnd", bus.operand, 19);
        drive(0, 1, 0, 0, 0); look; chk("b_faddr", bus.mem_addr, 5'h1F);
        drive(0, 1, 0, 0, 0); look;
        chk("wrap_pc", bus.pc, 0); chk("wrap_en", bus.en, 1); chk("wrap_op", bus.opcode, 2);

        // Asynchronous reset in the middle of a fetch.
        drive(0, 0, 0, 0, 0); look; chk("ar_rd_pre", bus.mem_rd, 1);
        @(posedge clk); #2; #1 rst_n = 0; #1;
        chk_zero("arst");
        @(posedge clk); #2 rst_n = 1;
        look; chk_zero("arel");
        drive(0, 1, 0, 0, 0); look; chk("arel_rd", bus.mem_rd, 0);

        // Random traffic against the model.
        for (int i = 0; i < Depth; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), 5'($urandom));
            rst_n = ($urandom_range(0, 299) != 0);
        end
        drive(0, 0, 0, 0, 0);
        rst_n = 1;
        look;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
